// File: rtl/apb_ucpd_pkg.sv
// Shared constants for the UCPD transmit path: state encodings, default phase lengths
// and the retry limit used when UCPD_TX_RETRY_EN is defined.
package apb_ucpd_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE = 3'd0;
  localparam tx_state_t ST_PRE  = 3'd1;
  localparam tx_state_t ST_SOP  = 3'd2;
  localparam tx_state_t ST_DATA = 3'd3;
  localparam tx_state_t ST_CRC  = 3'd4;
  localparam tx_state_t ST_EOP  = 3'd5;
  localparam tx_state_t ST_BIST = 3'd6;
  localparam tx_state_t ST_WAIT = 3'd7;

  localparam int unsigned DEF_PRE_BITS = 64;
  localparam int unsigned DEF_SOP_BITS = 20;
  localparam int unsigned DEF_CRC_BITS = 40;
  localparam int unsigned DEF_EOP_BITS = 5;
  localparam int unsigned DEF_SYM_BITS = 10;
  localparam int unsigned DEF_IFG_BITS = 25;

  localparam logic [1:0] RETRY_MAX = 2'd3;

endpackage

// File: rtl/apb_ucpd_tx_framer_if.sv
// Request/status bundle between the APB register block, TX FIFO and the frame sequencer.
interface apb_ucpd_tx_framer_if #(
  parameter int unsigned PAY_W = 10
);
  logic             ucpden;
  logic             bit_clk_red;
  logic             transwin_en;
  logic             tx_start;
  logic             tx_hrst;
  logic             tx_crst;
  logic             tx_bist;
  logic             rx_busy;
  logic             txdr_vld;
  logic [PAY_W-1:0] tx_paysize;

  logic             pre_en;
  logic             sop_en;
  logic             data_en;
  logic             crc_en;
  logic             eop_en;
  logic             bist_en;
  logic             wait_en;
  logic             bmc_en;
  logic             txfifo_ld_en;
  logic             txdr_req;
  logic             tx_msg_sent;
  logic             tx_msg_disc;
  logic             tx_hrst_sent;
  logic             tx_hrst_disc;
  logic             tx_und;
  logic             busy;

  modport slave (
    input  ucpden, bit_clk_red, transwin_en, tx_start, tx_hrst, tx_crst, tx_bist,
           rx_busy, txdr_vld, tx_paysize,
    output pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en, bmc_en,
           txfifo_ld_en, txdr_req, tx_msg_sent, tx_msg_disc, tx_hrst_sent,
           tx_hrst_disc, tx_und, busy
  );

  modport master (
    output ucpden, bit_clk_red, transwin_en, tx_start, tx_hrst, tx_crst, tx_bist,
           rx_busy, txdr_vld, tx_paysize,
    input  pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en, bmc_en,
           txfifo_ld_en, txdr_req, tx_msg_sent, tx_msg_disc, tx_hrst_sent,
           tx_hrst_disc, tx_und, busy
  );

endinterface

// File: rtl/apb_ucpd_tx_bitcnt.sv
// Bit-strobe counter; done flags the strobe on which the count reaches limit-1.
module apb_ucpd_tx_bitcnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             strobe,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign done = strobe && enable && (cnt == (limit - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (strobe && enable) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/apb_ucpd_tx_framer.sv
// USB-PD transmit frame sequencer: preamble, SOP, payload, CRC, EOP, inter-frame gap.
// Build macro UCPD_TX_RETRY_EN adds automatic retry of messages discarded for rx_busy.
module apb_ucpd_tx_framer
  import apb_ucpd_pkg::*;
#(
  parameter int unsigned PAY_W     = 10,
  parameter int unsigned PRE_BITS  = DEF_PRE_BITS,
  parameter int unsigned SOP_BITS  = DEF_SOP_BITS,
  parameter int unsigned CRC_BITS  = DEF_CRC_BITS,
  parameter int unsigned EOP_BITS  = DEF_EOP_BITS,
  parameter int unsigned SYM_BITS  = DEF_SYM_BITS,
  parameter int unsigned IFG_BITS  = DEF_IFG_BITS,
  parameter int unsigned BIST_BITS = 16'd1024,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 ic_clk,
  input logic                 ic_rst_n,
  apb_ucpd_tx_framer_if.slave bus
);

  localparam logic [PAY_W-1:0] PAY_ONE = PAY_W'(1);

  tx_state_t        state, state_nxt;
  logic             hrst_flag, crst_flag, bist_lat, hrst_pend, aborted;
  logic             hflag_nxt, cflag_nxt, blat_nxt, pend_nxt, abort_nxt;
  logic [PAY_W-1:0] pay_q, pay_nxt, byte_cnt, byte_nxt, last_byte;
  logic             ld_q, sent_q, disc_q, hsent_q, hdisc_q, und_q;
  logic             ld_nxt, sent_nxt, disc_nxt, hsent_nxt, hdisc_nxt, und_nxt;
  logic [CNT_W-1:0] limit;
  logic             done, bc_clr, pend_set, active, strobe;

`ifdef UCPD_TX_RETRY_EN
  logic [1:0] retry_cnt, retry_nxt;
  logic       win_q, win_first;

  assign win_first = bus.transwin_en && !win_q;
`endif

  assign active    = (state != ST_IDLE);
  assign strobe    = bus.bit_clk_red;
  assign last_byte = pay_q - PAY_ONE;
  // A hard-reset request while a frame is in flight is remembered rather than dropped.
  assign pend_set  = bus.tx_hrst && !hrst_flag && active;

  always_comb begin
    case (state)
      ST_PRE:  limit = CNT_W'(PRE_BITS);
      ST_SOP:  limit = CNT_W'(SOP_BITS);
      ST_DATA: limit = CNT_W'(SYM_BITS);
      ST_CRC:  limit = CNT_W'(CRC_BITS);
      ST_EOP:  limit = CNT_W'(EOP_BITS);
      ST_BIST: limit = CNT_W'(BIST_BITS);
      ST_WAIT: limit = CNT_W'(IFG_BITS);
      default: limit = '0;
    endcase
  end

  apb_ucpd_tx_bitcnt #(
    .CNT_W(CNT_W)
  ) u_bitcnt (
    .clk    (ic_clk),
    .rst_n  (ic_rst_n),
    .clr    (bc_clr),
    .strobe (strobe),
    .enable (active),
    .limit  (limit),
    .done   (done)
  );

  // The counter also serves as the in-byte symbol counter, so it restarts every byte.
  assign bc_clr = !bus.ucpden || done || (state_nxt != state);

  always_comb begin
    state_nxt = state;
    hflag_nxt = hrst_flag;
    cflag_nxt = crst_flag;
    blat_nxt  = bist_lat;
    pend_nxt  = hrst_pend || pend_set;
    abort_nxt = aborted;
    pay_nxt   = pay_q;
    byte_nxt  = byte_cnt;
    ld_nxt    = 1'b0;
    sent_nxt  = 1'b0;
    disc_nxt  = 1'b0;
    hsent_nxt = 1'b0;
    hdisc_nxt = 1'b0;
    und_nxt   = 1'b0;
`ifdef UCPD_TX_RETRY_EN
    retry_nxt = retry_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.transwin_en) begin
          if (hrst_pend || (bus.tx_hrst && !bus.rx_busy)) begin
            hflag_nxt = 1'b1;
            pend_nxt  = 1'b0;
            state_nxt = ST_PRE;
          end else if (bus.tx_hrst) begin
            hdisc_nxt = 1'b1;
          end else if (bus.tx_crst) begin
            cflag_nxt = 1'b1;
            state_nxt = ST_PRE;
          end else if (bus.tx_bist) begin
            blat_nxt  = 1'b1;
            state_nxt = ST_PRE;
          end else if (bus.tx_start && bus.rx_busy) begin
`ifdef UCPD_TX_RETRY_EN
            // One attempt per window; only the final failed attempt is reported.
            if (win_first) begin
              if (retry_cnt == RETRY_MAX) begin
                disc_nxt  = 1'b1;
                retry_nxt = '0;
              end else begin
                retry_nxt = retry_cnt + 2'd1;
              end
            end
`else
            disc_nxt = 1'b1;
`endif
          end else if (bus.tx_start) begin
            state_nxt = ST_PRE;
`ifdef UCPD_TX_RETRY_EN
            retry_nxt = '0;
`endif
          end
          if (state_nxt == ST_PRE) begin
            pay_nxt   = bus.tx_paysize;
            abort_nxt = 1'b0;
          end
        end
      end
      ST_PRE: begin
        if (done) begin
          state_nxt = ST_SOP;
          if (hrst_pend || pend_set) begin
            hflag_nxt = 1'b1;
            pend_nxt  = 1'b0;
          end
        end
      end
      ST_SOP: begin
        if (done) begin
          if (hrst_flag) begin
            state_nxt = ST_WAIT;
            hsent_nxt = 1'b1;
          end else if (crst_flag) begin
            state_nxt = ST_WAIT;
          end else if (bist_lat) begin
            state_nxt = ST_BIST;
          end else begin
            state_nxt = ST_DATA;
            ld_nxt    = 1'b1;
            byte_nxt  = '0;
          end
        end
      end
      ST_DATA: begin
        if (strobe && (hrst_pend || pend_set)) begin
          state_nxt = ST_EOP;
          abort_nxt = 1'b1;
        end else if (done) begin
          if (byte_cnt == last_byte) begin
            state_nxt = ST_CRC;
          end else begin
            ld_nxt   = 1'b1;
            byte_nxt = byte_cnt + PAY_ONE;
            if (!bus.txdr_vld) begin
              und_nxt   = 1'b1;
              state_nxt = ST_EOP;
              abort_nxt = 1'b1;
            end
          end
        end
      end
      ST_CRC: begin
        if (strobe && (hrst_pend || pend_set)) begin
          state_nxt = ST_EOP;
          abort_nxt = 1'b1;
        end else if (done) begin
          state_nxt = ST_EOP;
        end
      end
      ST_EOP: begin
        if (done) begin
          state_nxt = ST_WAIT;
          sent_nxt  = !aborted;
        end
      end
      ST_BIST: begin
        if (done) state_nxt = ST_WAIT;
      end
      default: begin
        if (done) begin
          state_nxt = ST_IDLE;
          hflag_nxt = 1'b0;
          cflag_nxt = 1'b0;
          blat_nxt  = 1'b0;
        end
      end
    endcase

    if (!bus.ucpden) begin
      state_nxt = ST_IDLE;
      hflag_nxt = 1'b0;
      cflag_nxt = 1'b0;
      blat_nxt  = 1'b0;
      pend_nxt  = 1'b0;
      abort_nxt = 1'b0;
      pay_nxt   = '0;
      byte_nxt  = '0;
      ld_nxt    = 1'b0;
      sent_nxt  = 1'b0;
      disc_nxt  = 1'b0;
      hsent_nxt = 1'b0;
      hdisc_nxt = 1'b0;
      und_nxt   = 1'b0;
`ifdef UCPD_TX_RETRY_EN
      retry_nxt = '0;
`endif
    end
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state     <= ST_IDLE;
      hrst_flag <= 1'b0;
      crst_flag <= 1'b0;
      bist_lat  <= 1'b0;
      hrst_pend <= 1'b0;
      aborted   <= 1'b0;
      pay_q     <= '0;
      byte_cnt  <= '0;
      ld_q      <= 1'b0;
      sent_q    <= 1'b0;
      disc_q    <= 1'b0;
      hsent_q   <= 1'b0;
      hdisc_q   <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hrst_flag <= hflag_nxt;
      crst_flag <= cflag_nxt;
      bist_lat  <= blat_nxt;
      hrst_pend <= pend_nxt;
      aborted   <= abort_nxt;
      pay_q     <= pay_nxt;
      byte_cnt  <= byte_nxt;
      ld_q      <= ld_nxt;
      sent_q    <= sent_nxt;
      disc_q    <= disc_nxt;
      hsent_q   <= hsent_nxt;
      hdisc_q   <= hdisc_nxt;
      und_q     <= und_nxt;
    end
  end

`ifdef UCPD_TX_RETRY_EN
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      retry_cnt <= '0;
      win_q     <= 1'b0;
    end else begin
      retry_cnt <= retry_nxt;
      win_q     <= bus.transwin_en;
    end
  end
`endif

  assign bus.pre_en       = (state == ST_PRE);
  assign bus.sop_en       = (state == ST_SOP);
  assign bus.data_en      = (state == ST_DATA);
  assign bus.crc_en       = (state == ST_CRC);
  assign bus.eop_en       = (state == ST_EOP);
  assign bus.bist_en      = (state == ST_BIST);
  assign bus.wait_en      = (state == ST_WAIT);
  assign bus.bmc_en       = active;
  assign bus.busy         = active;
  assign bus.txdr_req     = (state == ST_DATA) && (byte_cnt < last_byte);
  assign bus.txfifo_ld_en = ld_q;
  assign bus.tx_msg_sent  = sent_q;
  assign bus.tx_msg_disc  = disc_q;
  assign bus.tx_hrst_sent = hsent_q;
  assign bus.tx_hrst_disc = hdisc_q;
  assign bus.tx_und       = und_q;

endmodule

// File: tb/tb_apb_ucpd_tx_framer.sv
// Directed bench for apb_ucpd_tx_framer: table of frame requests with per-phase strobe counts.
module tb_apb_ucpd_tx_framer;

  localparam int K_START  = 0;
  localparam int K_CRST   = 1;
  localparam int K_BIST   = 2;
  localparam int K_UND    = 3;
  localparam int K_HRST   = 4;
  localparam int K_PAYCHG = 5;
  localparam int NVEC     = 8;

  typedef struct {
    int pre;  int sop;  int data; int crc;  int eop;   int bist; int wt;
    int ld;   int sent; int und;  int hsent; int disc; int hdisc; int req; int busyc;
  } cnt_t;

  typedef struct {
    int   kind;
    int   pay;
    cnt_t exp;
  } vec_t;

  logic ic_clk   = 1'b0;
  logic ic_rst_n = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  cnt_t tot      = '{default: 0};
  vec_t vecs[NVEC];
  logic [15:0] outv;

  always #5 ic_clk = ~ic_clk;

  apb_ucpd_tx_framer_if #(.PAY_W(10)) bus ();

  apb_ucpd_tx_framer #(
    .PAY_W(10), .PRE_BITS(64), .SOP_BITS(20), .CRC_BITS(40), .EOP_BITS(5),
    .SYM_BITS(10), .IFG_BITS(25), .BIST_BITS(1024), .CNT_W(16)
  ) dut (
    .ic_clk   (ic_clk),
    .ic_rst_n (ic_rst_n),
    .bus      (bus)
  );

  assign outv = {bus.pre_en, bus.sop_en, bus.data_en, bus.crc_en, bus.eop_en, bus.bist_en,
                 bus.wait_en, bus.bmc_en, bus.txfifo_ld_en, bus.txdr_req, bus.tx_msg_sent,
                 bus.tx_msg_disc, bus.tx_hrst_sent, bus.tx_hrst_disc, bus.tx_und, bus.busy};

  // Bit strobe: one cycle in four.
  initial begin
    int unsigned div;
    div = 0;
    bus.bit_clk_red = 1'b0;
    forever begin
      @(posedge ic_clk);
      #1;
      div = (div + 1) % 4;
      bus.bit_clk_red = (div == 0);
    end
  end

  always @(negedge ic_clk) begin
    if (bus.bit_clk_red) begin
      if (bus.pre_en)   tot.pre  += 1;
      if (bus.sop_en)   tot.sop  += 1;
      if (bus.data_en)  tot.data += 1;
      if (bus.crc_en)   tot.crc  += 1;
      if (bus.eop_en)   tot.eop  += 1;
      if (bus.bist_en)  tot.bist += 1;
      if (bus.wait_en)  tot.wt   += 1;
      if (bus.txdr_req) tot.req  += 1;
    end
    if (bus.txfifo_ld_en) tot.ld    += 1;
    if (bus.tx_msg_sent)  tot.sent  += 1;
    if (bus.tx_und)       tot.und   += 1;
    if (bus.tx_hrst_sent) tot.hsent += 1;
    if (bus.tx_msg_disc)  tot.disc  += 1;
    if (bus.tx_hrst_disc) tot.hdisc += 1;
    if (bus.busy)         tot.busyc += 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      n_tests++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int g;
    g = 0;
    while (!bus.busy && g < 200) begin
      tick();
      g++;
    end
    chk({tag, ".start_timeout"}, (g >= 200) ? 1 : 0, 0);
  endtask

  task automatic wait_data(input int base, input int n, input string tag);
    int g;
    g = 0;
    while ((tot.data - base) < n && g < 5000) begin
      tick();
      g++;
    end
    chk({tag, ".data_timeout"}, (g >= 5000) ? 1 : 0, 0);
  endtask

  function automatic vec_t mk(input int kind, input int pay, input int pre, input int sop,
                              input int data, input int crc, input int eop, input int bist,
                              input int wt, input int ld, input int sent, input int und,
                              input int hsent, input int req);
    vec_t v;
    v.kind      = kind;
    v.pay       = pay;
    v.exp.pre   = pre;   v.exp.sop  = sop;  v.exp.data = data;  v.exp.crc   = crc;
    v.exp.eop   = eop;   v.exp.bist = bist; v.exp.wt   = wt;    v.exp.ld    = ld;
    v.exp.sent  = sent;  v.exp.und  = und;  v.exp.hsent = hsent; v.exp.req  = req;
    v.exp.disc  = 0;     v.exp.hdisc = 0;   v.exp.busyc = -1;
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    cnt_t b;
    int   g;
    int   idle_run;
    b = tot;
    tick();
    bus.tx_paysize = 10'(v.pay);
    case (v.kind)
      K_CRST:  bus.tx_crst  = 1'b1;
      K_BIST:  bus.tx_bist  = 1'b1;
      default: bus.tx_start = 1'b1;
    endcase
    wait_busy(tag);
    bus.tx_start = 1'b0;
    bus.tx_crst  = 1'b0;
    bus.tx_bist  = 1'b0;
    if (v.kind == K_PAYCHG) bus.tx_paysize = 10'd7;
    if (v.kind == K_UND) begin
      wait_data(b.data, 10, tag);
      bus.txdr_vld = 1'b0;
    end
    if (v.kind == K_HRST) begin
      wait_data(b.data, 13, tag);
      bus.tx_hrst = 1'b1;
      tick();
      bus.tx_hrst = 1'b0;
    end
    g = 0;
    idle_run = 0;
    while (idle_run < 10 && g < 20000) begin
      tick();
      idle_run = bus.busy ? 0 : idle_run + 1;
      g++;
    end
    bus.txdr_vld = 1'b1;
    chk({tag, ".end_timeout"}, (g >= 20000) ? 1 : 0, 0);
    chk({tag, ".pre"},   tot.pre   - b.pre,   v.exp.pre);
    chk({tag, ".sop"},   tot.sop   - b.sop,   v.exp.sop);
    chk({tag, ".data"},  tot.data  - b.data,  v.exp.data);
    chk({tag, ".crc"},   tot.crc   - b.crc,   v.exp.crc);
    chk({tag, ".eop"},   tot.eop   - b.eop,   v.exp.eop);
    chk({tag, ".bist"},  tot.bist  - b.bist,  v.exp.bist);
    chk({tag, ".wait"},  tot.wt    - b.wt,    v.exp.wt);
    chk({tag, ".ld"},    tot.ld    - b.ld,    v.exp.ld);
    chk({tag, ".sent"},  tot.sent  - b.sent,  v.exp.sent);
    chk({tag, ".und"},   tot.und   - b.und,   v.exp.und);
    chk({tag, ".hsent"}, tot.hsent - b.hsent, v.exp.hsent);
    chk({tag, ".req"},   tot.req   - b.req,   v.exp.req);
    chk({tag, ".disc"},  tot.disc  - b.disc,  v.exp.disc);
    chk({tag, ".hdisc"}, tot.hdisc - b.hdisc, v.exp.hdisc);
  endtask

  initial begin
    cnt_t b;
    bus.ucpden      = 1'b1;
    bus.transwin_en = 1'b1;
    bus.tx_start    = 1'b0;
    bus.tx_hrst     = 1'b0;
    bus.tx_crst     = 1'b0;
    bus.tx_bist     = 1'b0;
    bus.rx_busy     = 1'b0;
    bus.txdr_vld    = 1'b1;
    bus.tx_paysize  = 10'd2;

    //            kind      pay pre  sop data crc eop bist  wait ld sent und hs req
    vecs[0] = mk(K_START,  2,  64,  20, 20,  40, 5,  0,    25,  2, 1,   0,  0, 10);
    vecs[1] = mk(K_START,  1,  64,  20, 10,  40, 5,  0,    25,  1, 1,   0,  0, 0);
    vecs[2] = mk(K_START,  3,  64,  20, 30,  40, 5,  0,    25,  3, 1,   0,  0, 20);
    vecs[3] = mk(K_CRST,   2,  64,  20, 0,   0,  0,  0,    25,  0, 0,   0,  0, 0);
    vecs[4] = mk(K_BIST,   2,  64,  20, 0,   0,  0,  1024, 25,  0, 0,   0,  0, 0);
    vecs[5] = mk(K_UND,    3,  64,  20, 20,  0,  5,  0,    25, -1, 0,   1,  0, 20);
    vecs[6] = mk(K_HRST,   3,  128, 40, 14,  0,  5,  0,    50,  2, 0,   0,  1, 14);
    vecs[7] = mk(K_PAYCHG, 2,  64,  20, 20,  40, 5,  0,    25,  2, 1,   0,  0, 10);

    repeat (3) @(posedge ic_clk);
    @(negedge ic_clk);
    chk("reset.outs", int'(outv), 0);
    tick();
    ic_rst_n = 1'b1;
    tick();
    chk("reset.idle_outs", int'(outv), 0);

    for (int i = 0; i < NVEC; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Message request while the receiver owns the line.
    b = tot;
    bus.rx_busy = 1'b1;
`ifdef UCPD_TX_RETRY_EN
    bus.tx_start = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus.transwin_en = 1'b0;
      tick();
      bus.transwin_en = 1'b1;
      tick();
      tick();
      if (w == 2) chk("retry.early_disc", tot.disc - b.disc, 0);
    end
    bus.tx_start = 1'b0;
`else
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
`endif
    repeat (3) tick();
    chk("disc.pulses", tot.disc - b.disc, 1);
    chk("disc.busy", tot.busyc - b.busyc, 0);

    b = tot;
    bus.tx_hrst = 1'b1;
    tick();
    bus.tx_hrst = 1'b0;
    repeat (3) tick();
    bus.rx_busy = 1'b0;
    chk("hdisc.pulses", tot.hdisc - b.hdisc, 1);
    chk("hdisc.busy", tot.busyc - b.busyc, 0);

    // Block disable in the middle of the payload.
    b = tot;
    bus.tx_paysize = 10'd2;
    bus.tx_start = 1'b1;
    wait_busy("en");
    bus.tx_start = 1'b0;
    wait_data(b.data, 5, "en");
    bus.ucpden = 1'b0;
    tick();
    chk("en.outs", int'(outv), 0);
    bus.ucpden = 1'b1;
    repeat (2) tick();
    chk("en.stay_idle", int'(bus.busy), 0);
    run_frame(vecs[0], "after_en");

    // Asynchronous reset in the middle of the payload.
    b = tot;
    bus.tx_start = 1'b1;
    wait_busy("rst");
    bus.tx_start = 1'b0;
    wait_data(b.data, 5, "rst");
    ic_rst_n = 1'b0;
    #2;
    chk("rst.outs", int'(outv), 0);
    tick();
    ic_rst_n = 1'b1;
    tick();
    chk("rst.stay_idle", int'(bus.busy), 0);
    run_frame(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_ucpd_tx_framer.md
Name: apb_ucpd_tx_framer

Overview:
- Parametrised, single-clock successor to the PD transmit sequencer.
- Sequences one USB-PD frame: preamble, SOP ordered-set, 4b5b-coded payload, CRC, EOP, then an inter-frame gap.
- Adds to the previous generation: parametrised phase lengths, an internally counted inter-frame gap, a TX FIFO ready check with underrun abort, a queued hard reset that can follow an aborted message, and BIST carrier length control.
- Sits between the APB register block/TX FIFO and the BMC encoder, in the ic_clk domain.

Parameters:
- PAY_W, 10, width of the payload byte count.
- PRE_BITS, 64, preamble length in bits.
- SOP_BITS, 20, ordered-set length in bits (4 K-codes x 5).
- CRC_BITS, 40, CRC length in bits (8 symbols x 5).
- EOP_BITS, 5, EOP length in bits.
- SYM_BITS, 10, encoded bits per payload byte.
- IFG_BITS, 25, inter-frame gap length in bit strobes.
- BIST_BITS, 16'd1024, BIST carrier length in bits.
- CNT_W, 16, width of the bit counter; must hold the largest *_BITS value.

Ports:
- ic_clk  in  1  UCPD kernel clock (HSI16); the block's only clock.
- ic_rst_n  in  1  asynchronous active-low reset.
- ucpden  in  1  block enable; 0 forces IDLE synchronously and clears counters and flags.
- bit_clk_red  in  1  one-cycle bit strobe.
- transwin_en  in  1  transmit window open.
- tx_start  in  1  level request to send a message.
- tx_hrst  in  1  level request to send a hard reset.
- tx_crst  in  1  level request to send a cable reset.
- tx_bist  in  1  level request to send a BIST carrier.
- rx_busy  in  1  receiver is active on the line.
- txdr_vld  in  1  TX data byte available.
- tx_paysize  in  PAY_W  payload bytes, must be >= 1.
- pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en  out  1 each  one-hot phase enables.
- bmc_en  out  1  OR of all phase enables except IDLE; also drives cc_oen.
- txfifo_ld_en  out  1  one-cycle strobe to load the next byte.
- txdr_req  out  1  more payload bytes are still needed.
- tx_msg_sent, tx_msg_disc, tx_hrst_sent, tx_hrst_disc, tx_und  out  1 each  one-cycle status pulses.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and the flags hrst_flag, crst_flag and hrst_pend are 0.
- Phase completion: a phase ends on the strobe where bit_cnt == N-1 (N = that phase's *_BITS). bit_cnt advances only on bit_clk_red while bmc_en=1 and is cleared when a phase ends.
- IDLE, checked in priority order when transwin_en=1:
  - tx_hrst or hrst_pend: set hrst_flag, go to PRE. A pending hard reset is never discarded.
  - tx_crst: set crst_flag, go to PRE.
  - tx_bist: go to PRE.
  - tx_start and rx_busy=1: pulse tx_msg_disc, stay in IDLE. tx_hrst together with rx_busy pulses tx_hrst_disc only when hrst_pend=0.
  - tx_start: go to PRE.
- PRE -> SOP after PRE_BITS.
- SOP, after SOP_BITS:
  - hrst_flag: go to WAIT and pulse tx_hrst_sent.
  - crst_flag: go to WAIT.
  - BIST request latched: go to BIST.
  - otherwise: go to DATA and pulse txfifo_ld_en.
- DATA:
  - byte_cnt counts bytes; sym_cnt cycles 0..SYM_BITS-1.
  - At the last bit of a byte: if byte_cnt == tx_paysize-1, go to CRC. Otherwise pulse txfifo_ld_en and increment byte_cnt; if txdr_vld=0 at that point, pulse tx_und and go to EOP.
  - txdr_req = data_en && byte_cnt < tx_paysize-1.
- CRC -> EOP after CRC_BITS.
- EOP -> WAIT after EOP_BITS; pulse tx_msg_sent unless the frame was aborted.
- BIST -> WAIT after BIST_BITS.
- WAIT -> IDLE after IFG_BITS strobes.
- Flags hrst_flag, crst_flag and the BIST latch clear on entry to IDLE.
- Mid-frame tx_hrst (state PRE/DATA/CRC/BIST, hrst_flag=0): set hrst_pend.
  - DATA/CRC: go to EOP at the next bit strobe; the abort suppresses tx_msg_sent.
  - PRE: complete the preamble, then take the hard-reset branch at SOP. hrst_pend clears when hrst_flag sets.
- tx_hrst during EOP/WAIT sets hrst_pend with no truncation.
- Simultaneous phase end and tx_hrst: the abort wins.
- tx_paysize is sampled on leaving IDLE; changes mid-frame are ignored.

Optional Feature:
- Macro UCPD_TX_RETRY_EN.
- When defined, a discarded tx_start is retried automatically up to 3 times on the next transwin_en window, tracked by a 2-bit retry_cnt; tx_msg_disc pulses only on the final failed attempt.
- When undefined, tx_msg_disc pulses on the first discard and there is no retry_cnt logic.

Decomposition:
- Shared package apb_ucpd_pkg holds:
  - TX state encodings (3-bit);
  - default PRE/SOP/CRC/EOP/SYM/IFG bit counts;
  - retry limit constant.
- Sub-module apb_ucpd_tx_bitcnt: bit counter with a phase-end compare (inputs: strobe, enable, limit; output: done).

Test Plan:
- tx_paysize=2, txdr_vld=1, strobe every 4 cycles -> phase sequence PRE64, SOP20, DATA20, CRC40, EOP5, WAIT25; txfifo_ld_en pulses exactly 2 times; tx_msg_sent pulses once.
- tx_start with rx_busy=1 -> tx_msg_disc pulses one cycle, busy stays 0; with UCPD_TX_RETRY_EN, the pulse appears after the 4th window only.
- tx_hrst asserted at DATA byte 1, bit 3 -> EOP at the next strobe, then WAIT, IDLE, PRE, SOP, tx_hrst_sent; tx_msg_sent never pulses.
- tx_paysize=3, txdr_vld drops before byte 2 -> tx_und pulses at the byte-1 boundary, then EOP; no CRC phase.
- tx_crst -> PRE, SOP, WAIT, IDLE with no DATA; tx_bist -> bist_en high for exactly 1024 strobes.
- Mid-DATA ucpden=0 for 1 cycle, or an ic_rst_n pulse -> IDLE immediately with all outputs 0; the next tx_start runs a clean full frame.
